// File: rtl/if_id_fetch_buffer_pkg.sv
// Shared fetch/decode pipeline types and constants.
// Imported by the fetch buffer and its storage array.
package if_id_fetch_buffer_pkg;

    localparam int DEFAULT_DW = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_bundle_t;

endpackage

// File: rtl/if_id_fetch_buffer_mem.sv
// Register array for the fetch buffer.
// One synchronous write port and one combinational read port.
module fetch_buffer_mem
    import if_id_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = DEFAULT_DW
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [2*DW-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [2*DW-1:0] rdata
);

    logic [2*DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_fetch_buffer.sv
// In-order FIFO between fetch and decode.
// Freezes fetch when full; a taken branch empties it.
module if_id_fetch_buffer
    import if_id_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] if_pc,
    input  logic [DW-1:0] if_instr,
    input  logic          flush,
    input  logic          id_stall,
    output logic          if_freeze,
    output logic          id_valid,
    output logic [DW-1:0] id_pc,
    output logic [DW-1:0] id_instr,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full, empty;
    logic            push, pop;
    logic [2*DW-1:0] rdata;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = ~full & ~flush;
    assign pop   = ~empty & ~id_stall & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push & ~pop) count_d = count_q + 1'b1;
            if (pop & ~push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_buffer_mem #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_mem (
        .clk  (clk),
        .we   (push & ~rst),
        .waddr(wr_ptr_q),
        .wdata({if_pc, if_instr}),
        .raddr(rd_ptr_q),
        .rdata(rdata)
    );

    // An empty buffer presents a NOP bubble to decode.
    assign if_freeze = full;
    assign id_valid  = ~empty;
    assign id_pc     = id_valid ? rdata[2*DW-1:DW] : '0;
    assign id_instr  = id_valid ? rdata[DW-1:0] : DW'(NOP_INSTR);
    assign count     = count_q;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Directed table plus randomized run against a queue model.
module tb_if_id_fetch_buffer;
    import if_id_fetch_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        flush = 1'b0;
    logic        id_stall = 1'b0;
    logic        if_freeze;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  count;

    if_id_fetch_buffer #(.DEPTH(4), .AW(2), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .flush    (flush),
        .id_stall (id_stall),
        .if_freeze(if_freeze),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, f, s;
        logic [31:0] pc, instr;
        int          e_cnt;
        logic        e_val;
        logic [31:0] e_pc, e_instr;
        logic        e_frz;
    } vec_t;

    vec_t       tbl [80];
    int         n_vec = 0;
    int         tests = 0;
    int         fails = 0;
    fd_bundle_t mq [$];

    task automatic add(input logic r, f, s, input logic [31:0] pc, instr,
                       input int c, input logic v, input logic [31:0] epc,
                       input logic [31:0] ein, input logic fz);
        tbl[n_vec] = '{r, f, s, pc, instr, c, v, epc, ein, fz};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(logic r, f, s, logic [31:0] pc, ins);
        bit was_full;
        if (r || f) begin
            mq.delete();
        end else begin
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && !s) void'(mq.pop_front());
            if (!was_full) mq.push_back('{pc: pc, instr: ins});
        end
    endfunction

    task automatic step(input logic r, f, s, input logic [31:0] pc, ins);
        rst = r; flush = f; id_stall = s; if_pc = pc; if_instr = ins;
        @(posedge clk);
        model_step(r, f, s, pc, ins);
        #1;
    endtask

    task automatic check_outs(input string tag, input int c, input logic v,
                              input logic [31:0] p, ins, input logic fz);
        logic [1:0] diff;
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".valid"}, 32'(id_valid), 32'(v));
        chk({tag, ".pc"}, id_pc, p);
        chk({tag, ".instr"}, id_instr, ins);
        chk({tag, ".freeze"}, 32'(if_freeze), 32'(fz));
        if (count != 3'd4) begin
            diff = dut.wr_ptr_q - dut.rd_ptr_q;
            chk({tag, ".ptrinv"}, 32'(count), 32'(diff));
        end
    endtask

    initial begin
        logic [31:0] e;
        e = 32'hE3A0_1000;
        // reset with pushes offered
        add(1, 0, 0, 4, e + 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4, e + 1, 0, 0, 0, 0, 0);
        // fill while stalled; 5th not stored
        for (int k = 1; k <= 4; k++)
            add(0, 0, 1, 32'(4 * k), e + 32'(k), k, 1, 4, e + 1, k == 4);
        add(0, 0, 1, 20, e + 5, 4, 1, 4, e + 1, 1);
        // flush while full and stalled; flush-cycle instr dropped
        add(0, 1, 1, 32'h40, 32'hDEAD_0001, 0, 0, 0, 0, 0);
        // empty-to-first latency
        add(0, 0, 1, 32'h104, 32'hE280_0001, 1, 1, 32'h104, 32'hE280_0001, 0);
        // drain with concurrent push at count=2, wraps pointers
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 4, e + 1, 1, 1, 4, e + 1, 0);
        add(0, 0, 1, 8, e + 2, 2, 1, 4, e + 1, 0);
        for (int k = 3; k <= 12; k++)
            add(0, 0, 0, 32'(4 * k), e + 32'(k), 2, 1,
                32'(4 * (k - 1)), e + 32'(k - 1), 0);
        // reset mid-operation at count=3 overrides flush
        add(0, 0, 1, 52, e + 13, 3, 1, 44, e + 11, 0);
        add(1, 1, 0, 56, e + 14, 0, 0, 0, 0, 0);
        add(0, 0, 1, 32'h104, 32'hE280_0001, 1, 1, 32'h104, 32'hE280_0001, 0);
        // back-to-back flushes
        add(0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2, 2, 0, 0, 0, 0, 0);
        // full then pop: freeze drops after the pop
        for (int k = 1; k <= 4; k++)
            add(0, 0, 1, 32'(4 * k), e + 32'(k), k, 1, 4, e + 1, k == 4);
        add(0, 0, 0, 20, e + 5, 3, 1, 8, e + 2, 0);
        add(0, 0, 0, 24, e + 6, 3, 1, 12, e + 3, 0);

        for (int i = 0; i < n_vec; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].pc, tbl[i].instr);
            check_outs($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_val,
                       tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_frz);
        end

        // randomized run against the queue model
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic r, f, s;
            r = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 11) == 0);
            s = ($urandom_range(0, 99) < (i % 400 < 200 ? 70 : 30));
            step(r, f, s, $urandom, $urandom);
            check_outs("rand", mq.size(), mq.size() > 0,
                       mq.size() > 0 ? mq[0].pc : 32'h0,
                       mq.size() > 0 ? mq[0].instr : NOP_INSTR,
                       mq.size() == DEPTH);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
- Small in-order FIFO between the fetch stage and the decode stage.
- Each entry holds one fetched instruction and its PC+4 value.
- Lets fetch run ahead while decode stalls. Drives the fetch stage's freeze input when full.
- Discards all buffered entries when a branch is taken.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).
- DW, 32, width of instruction and PC fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- if_pc  input  DW  PC+4 value from the fetch stage.
- if_instr  input  DW  fetched instruction.
- flush  input  1  branch taken; discard all entries.
- id_stall  input  1  decode cannot accept this cycle (hazard or memory freeze).
- if_freeze  output  1  to fetch freeze input; equals full.
- id_valid  output  1  head entry is valid.
- id_pc  output  DW  head entry PC+4.
- id_instr  output  DW  head entry instruction.
- count  output  AW+1  current occupancy, 0 to DEPTH.

Behaviour:
- All state updates occur on the rising edge of clk. rst is synchronous and active-high.
- Reset: wr_ptr=0, rd_ptr=0, count=0, id_valid=0, id_pc=0, id_instr=0, if_freeze=0. Storage contents are don't-care.
- Reset asserted mid-operation: the next edge empties the buffer. Reset overrides flush, push and pop.
- Full/empty: full = (count==DEPTH); empty = (count==0).
- if_freeze = full. Combinational from count only; no path from flush or id_stall, so there is no combinational loop.
- push = ~full & ~flush. Fetch delivers one instruction every non-frozen cycle, so there is no separate valid input.
- On push: mem[wr_ptr] <= {if_pc, if_instr}; wr_ptr increments.
- pop = id_valid & ~id_stall & ~flush. On pop, rd_ptr increments.
- Pointers are AW bits and wrap modulo DEPTH. count tracks occupancy separately so full and empty are unambiguous.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Push and pop in the same cycle is legal when 0 < count < DEPTH; count is unchanged.
- Full: no push. Pop proceeds normally. Fetch is frozen, so its outputs hold and nothing is lost. if_freeze drops in the cycle after the pop.
- Empty: id_valid=0 and no pop. A push into an empty buffer makes the entry visible on id_* in the next cycle.
  - Latency from fetch to decode is 1 cycle.
  - There is no same-cycle bypass.
- Outputs:
  - id_valid = ~empty.
  - id_pc and id_instr = mem[rd_ptr] when id_valid=1; 0 when id_valid=0.
  - Zero is the team NOP, so decode sees a bubble when the buffer is empty.
- Flush (flush=1, rst=0), effect at the next edge:
  - wr_ptr <= 0, rd_ptr <= 0, count <= 0. No push, no pop.
  - The instruction fetched in the flush cycle is on the wrong path and is dropped.
  - id_valid=0 in the following cycle.
  - flush with id_stall=1: flush wins and the stalled head is discarded.
  - flush while full: the buffer empties and if_freeze deasserts in the next cycle.
  - flush on consecutive cycles keeps the buffer empty.
- Invariants checked by the bench:
  - count == (wr_ptr - rd_ptr) mod DEPTH, except when count == DEPTH.
  - Entries leave in arrival order.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR = 32'h0000_0000.
  - Default DW = 32.
  - Fetch/decode bundle typedef {pc[31:0], instr[31:0]}.
- One sub-module, fetch_buffer_mem:
  - DEPTH x 2*DW register array.
  - Synchronous write port (we, waddr, wdata).
  - Combinational read port (raddr, rdata).
  - No reset on storage.
- Pointers, count, flush and output muxing live in if_id_fetch_buffer.

Test Plan:
- Reset: hold rst=1 for 2 cycles with pushes offered -> count=0, id_valid=0, id_instr=0, id_pc=0, if_freeze=0.
- Fill: id_stall=1; push instr 0xE3A01001..0xE3A01004 with pc 4, 8, 12, 16 -> count=4, if_freeze=1 after the 4th edge. A 5th offered value 0xE3A01005 is not stored. id_instr=0xE3A01001 throughout.
- Drain with concurrent push:
  - Release id_stall with the buffer at count=2, continuing pushes -> count stays 2.
  - Head order on consecutive cycles is 0xE3A01001, 0xE3A01002, ...
  - Pointers wrap past DEPTH-1 with correct data over 10 transfers.
- Flush while full and stalled: flush=1 for 1 cycle at count=4 with id_stall=1 -> next cycle count=0, id_valid=0, if_freeze=0. The instruction presented in the flush cycle is never output.
- Empty-to-first latency: push 0xE2800001 with pc=0x104 into an empty buffer -> id_valid=1, id_instr=0xE2800001, id_pc=0x104 exactly one cycle later.
- Reset mid-operation: at count=3 assert rst together with flush and id_stall=0 -> next cycle count=0, id_valid=0. Normal push resumes the cycle after rst deasserts.
